// File: rtl/mac_dot_seq_pkg.sv
// mac_dot_seq_pkg
//   Shared definitions for the dot-product MAC sequencer. It holds the FSM
//   state type and the default accumulator/normaliser latencies, so the
//   datapath owners can change them in one place.
package mac_dot_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    NORM  = 2'd3
  } state_t;

  // Cycles from the Kth accepted beat until the carry-save words are final.
  localparam int ACC_LAT_DEF  = 4;
  // Register depth of the normaliser (regime -> sf/mantissa partials -> sum).
  localparam int NORM_LAT_DEF = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mac_dot_seq_sat_counter.sv
// sat_counter
//   Saturating up-counter used for the overflow/underflow statistics.
//   Ports:
//     clk_i  - clock
//     rst_i  - synchronous active-high reset (count -> 0)
//     inc_i  - add one, unless the count is already all-ones
//     clr_i  - synchronous clear (takes priority over inc_i)
//     cnt_o  - current count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mac_dot_seq.sv
// mac_dot_seq
//   Sequencer for the dot-product MAC datapath. It counts K accepted operand
//   beats, waits for the accumulator pipeline to drain, enables the
//   normaliser for its full register depth, clears the accumulator and
//   presents the result on a valid/ready handshake. It also keeps saturating
//   overflow/underflow statistics.
//   Ports:
//     clk_i, rst_i             - clock, synchronous active-high reset
//     flush_i                  - abort current dot product and pending result
//     in_valid_i / in_ready_o  - operand beat handshake
//     vld_d_o                  - valid history to the datapath stages
//     acc_rdy_o                - normaliser update enable
//     acc_clr_o                - one-cycle accumulator clear
//     ovf_i, udf_i, nzero_i    - normaliser flags
//     out_valid_o/out_ready_i  - result handshake
//     ovf_cnt_o, udf_cnt_o     - saturating event counters
module mac_dot_seq
  import mac_dot_seq_pkg::*;
#(
  parameter int K         = 9,
  parameter int VLD_DEPTH = 12,
  parameter int ACC_LAT   = ACC_LAT_DEF,
  parameter int NORM_LAT  = NORM_LAT_DEF,
  parameter int CNT_W     = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic [VLD_DEPTH-1:0] vld_d_o,
  output logic                 acc_rdy_o,
  output logic                 acc_clr_o,
  input  logic                 ovf_i,
  input  logic                 udf_i,
  input  logic                 nzero_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [CNT_W-1:0]     ovf_cnt_o,
  output logic [CNT_W-1:0]     udf_cnt_o
);

  localparam int CW = $clog2(K + 1);
  localparam int TW = $clog2(max_int(ACC_LAT, NORM_LAT) + 1);

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [TW-1:0]        t_q, t_d;
  logic [VLD_DEPTH-2:0] hist_q, hist_d;
  logic                 res_pend_q, res_pend_d;
  logic                 acc_clr_q, acc_clr_d;

  logic                 fire;
  logic                 out_fire;
  logic [VLD_DEPTH-1:0] hist_shift;

  assign in_ready_o  = (state_q == IDLE) || (state_q == ACCUM);
  assign fire        = in_valid_i & in_ready_o;
  assign out_valid_o = res_pend_q;
  assign out_fire    = res_pend_q & out_ready_i;
  assign hist_shift  = {hist_q, fire};

  // Bit 0 stays high for the whole life of a frame and its pending result,
  // so the normaliser never sees an all-zero history mid-flight.
  assign vld_d_o   = {hist_q, fire | (state_q != IDLE) | res_pend_q};
  // A flush suppresses the normaliser update in its own cycle and clears
  // the accumulator immediately.
  assign acc_rdy_o = (state_q == NORM) & ~flush_i;
  assign acc_clr_o = acc_clr_q | flush_i;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    t_d        = t_q;
    hist_d     = hist_shift[VLD_DEPTH-2:0];
    res_pend_d = res_pend_q;
    acc_clr_d  = 1'b0;

    if (out_fire) begin
      res_pend_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (fire) begin
          state_d = ACCUM;
          cnt_d   = CW'(1);
        end
      end
      ACCUM: begin
        if (fire) begin
          if (cnt_q == CW'(K - 1)) begin
            state_d = DRAIN;
            cnt_d   = '0;
            t_d     = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DRAIN: begin
        // Timer holds at its final value while an older result is unread.
        if (t_q == TW'(ACC_LAT - 1)) begin
          if (!res_pend_q || out_fire) begin
            state_d = NORM;
            t_d     = '0;
          end
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      NORM: begin
        if (t_q == TW'(NORM_LAT - 1)) begin
          state_d    = IDLE;
          t_d        = '0;
          acc_clr_d  = 1'b1;
          res_pend_d = 1'b1;
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush_i) begin
      state_d    = IDLE;
      cnt_d      = '0;
      t_d        = '0;
      hist_d     = '0;
      res_pend_d = 1'b0;
      acc_clr_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      t_q        <= '0;
      hist_q     <= '0;
      res_pend_q <= 1'b0;
      acc_clr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      t_q        <= t_d;
      hist_q     <= hist_d;
      res_pend_q <= res_pend_d;
      acc_clr_q  <= acc_clr_d;
    end
  end

  // Flags are sampled in the cycle the result becomes visible, i.e. the
  // cycle after NORM, which is exactly when acc_clr_q is high. A result
  // aborted by a flush in that cycle is not counted.
  logic             sample;
  logic [1:0]       stat_inc;
  logic [CNT_W-1:0] stat_cnt [2];

  assign sample      = acc_clr_q & ~flush_i;
  assign stat_inc[0] = sample & ovf_i;
  assign stat_inc[1] = sample & udf_i & nzero_i; // exact zero is not an underflow

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_stat
      sat_counter #(.W(CNT_W)) u_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (stat_inc[gi]),
        .clr_i (1'b0),
        .cnt_o (stat_cnt[gi])
      );
    end
  endgenerate

  assign ovf_cnt_o = stat_cnt[0];
  assign udf_cnt_o = stat_cnt[1];

endmodule

// File: tb/tb_mac_dot_seq.sv
// tb_mac_dot_seq
//   Directed bench for mac_dot_seq with a timestamp-based reference model
//   checked every cycle, plus hand-computed literal expectations.
module tb_mac_dot_seq;

  localparam int K   = 9;
  localparam int VD  = 12;
  localparam int AL  = 4;
  localparam int NL  = 3;
  localparam int CW  = 2;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_i, flush_i, in_valid_i, out_ready_i;
  logic          ovf_i, udf_i, nzero_i;
  logic          in_ready_o, acc_rdy_o, acc_clr_o, out_valid_o;
  logic [VD-1:0] vld_d_o;
  logic [CW-1:0] ovf_cnt_o, udf_cnt_o;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  mac_dot_seq #(
    .K(K), .VLD_DEPTH(VD), .ACC_LAT(AL), .NORM_LAT(NL), .CNT_W(CW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .vld_d_o     (vld_d_o),
    .acc_rdy_o   (acc_rdy_o),
    .acc_clr_o   (acc_clr_o),
    .ovf_i       (ovf_i),
    .udf_i       (udf_i),
    .nzero_i     (nzero_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .ovf_cnt_o   (ovf_cnt_o),
    .udf_cnt_o   (udf_cnt_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  // ---------------- reference model (event timestamps) ----------------
  bit      fire_log [4096];
  int      m_frame, m_kcyc, m_nstart, m_floor, m_clr_at, m_ovf, m_udf;
  bit      m_pend, pend_next, e_busy, e_fire, e_rdy, e_clr, out_fire;
  logic [VD-1:0] e_vld;
  int      x, src;

  always @(negedge clk) begin
    x = cyc;
    if (rst_i) begin
      m_frame = 0; m_kcyc = -1; m_nstart = -1; m_pend = 0;
      m_floor = x + 1; m_clr_at = -1; m_ovf = 0; m_udf = 0;
    end else begin
      // A frame is "busy" from the cycle after its Kth beat until its
      // result is published.
      e_busy = (m_kcyc >= 0);
      e_fire = in_valid_i && !e_busy;
      e_rdy  = e_busy && (m_nstart >= 0) && (x >= m_nstart) &&
               (x < m_nstart + NL) && !flush_i;
      e_clr  = flush_i || (x == m_clr_at);
      e_vld  = '0;
      e_vld[0] = e_fire || e_busy || (m_frame > 0) || m_pend;
      for (int i = 1; i < VD; i++) begin
        src = x - i;
        if (src >= m_floor) e_vld[i] = fire_log[src % 4096];
      end

      chk("in_ready",  32'(in_ready_o),  32'(!e_busy));
      chk("acc_rdy",   32'(acc_rdy_o),   32'(e_rdy));
      chk("acc_clr",   32'(acc_clr_o),   32'(e_clr));
      chk("out_valid", 32'(out_valid_o), 32'(m_pend));
      chk("vld_d",     32'(vld_d_o),     32'(e_vld));
      chk("ovf_cnt",   32'(ovf_cnt_o),   32'(m_ovf));
      chk("udf_cnt",   32'(udf_cnt_o),   32'(m_udf));

      out_fire = out_ready_i && m_pend;
      if (flush_i) begin
        m_frame = 0; m_kcyc = -1; m_nstart = -1; m_pend = 0;
        m_floor = x + 1; m_clr_at = -1;
      end else begin
        if (x == m_clr_at) begin
          if (ovf_i && m_ovf < SAT) m_ovf++;
          if (udf_i && nzero_i && m_udf < SAT) m_udf++;
        end
        fire_log[x % 4096] = e_fire;
        pend_next = m_pend;
        if (out_fire) pend_next = 0;
        if (e_busy && m_nstart < 0 && x >= m_kcyc + AL && (!m_pend || out_fire)) begin
          m_nstart = x + 1;
        end else if (e_busy && m_nstart >= 0 && x == m_nstart + NL - 1) begin
          pend_next = 1; m_clr_at = x + 1; m_kcyc = -1; m_nstart = -1;
        end
        if (e_fire) begin
          m_frame++;
          if (m_frame == K) begin
            m_kcyc = x; m_frame = 0;
          end
        end
        m_pend = pend_next;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic look();
    @(negedge clk); #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready_o),  32'd1);
    chk({tag, "_acc_rdy"},   32'(acc_rdy_o),   32'd0);
    chk({tag, "_acc_clr"},   32'(acc_clr_o),   32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid_o), 32'd0);
    chk({tag, "_vld_d"},     32'(vld_d_o),     32'd0);
    chk({tag, "_ovf_cnt"},   32'(ovf_cnt_o),   32'd0);
    chk({tag, "_udf_cnt"},   32'(udf_cnt_o),   32'd0);
  endtask

  task automatic run_frame(input logic o, input logic u, input logic nz);
    ovf_i = o; udf_i = u; nzero_i = nz;
    for (int j = 0; j < K; j++) begin
      in_valid_i = 1'b1;
      tick();
    end
    in_valid_i = 1'b0;
    repeat (12) tick();
    ovf_i = 1'b0; udf_i = 1'b0; nzero_i = 1'b0;
  endtask

  int b, r, g, fs, n_clr, clr_j;

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    ovf_i = 1'b0; udf_i = 1'b0; nzero_i = 1'b0;
    repeat (3) tick();
    rst_i = 1'b0;
    look();
    chk_reset_vals("reset");
    tick();

    // Back-to-back frames with in_valid held high; Kth fire at b+8.
    in_valid_i = 1'b1;
    b = cyc;
    for (int j = 0; j < 18; j++) begin
      look();
      chk("t1_acc_rdy",  32'(acc_rdy_o),   32'(j >= 13 && j <= 15));
      chk("t1_in_ready", 32'(in_ready_o),  32'(!(j >= 9 && j <= 15)));
      chk("t1_acc_clr",  32'(acc_clr_o),   32'(j == 16));
      chk("t1_out_vld",  32'(out_valid_o), 32'(j == 16));
      tick();
    end

    // Second result stays unread; third frame must stall in DRAIN.
    out_ready_i = 1'b0;
    for (int j = 0; j < 100 && cyc < b + 50; j++) tick();
    r = cyc;
    out_ready_i = 1'b1;
    in_valid_i  = 1'b0;
    for (int j = 0; j < 5; j++) begin
      look();
      chk("stall_acc_rdy", 32'(acc_rdy_o),   32'(j >= 1 && j <= 3));
      chk("stall_out_vld", 32'(out_valid_o), 32'(j == 0 || j == 4));
      tick();
    end
    repeat (4) tick();

    // Gapped input: fires at g, g+2, ..., g+16.
    g = cyc;
    for (int j = 0; j < 17; j++) begin
      in_valid_i = (j % 2 == 0);
      look();
      if (j == 4) chk("gap_vld_d4", 32'(vld_d_o), 32'h015);
      if (j == 5) chk("gap_vld_d5", 32'(vld_d_o), 32'h02B);
      tick();
    end
    in_valid_i = 1'b0;
    repeat (12) tick();

    // Flush on the 5th fire, then exactly nine more fires.
    in_valid_i = 1'b1;
    for (int j = 0; j < 5; j++) begin
      flush_i = (j == 4);
      look();
      if (j == 4) chk("flush_clr", 32'(acc_clr_o), 32'd1);
      tick();
    end
    flush_i = 1'b0;
    fs = cyc;
    n_clr = 0; clr_j = -1;
    for (int j = 0; j < 31; j++) begin
      in_valid_i = (j < K);
      look();
      if (j == 0) begin
        chk("flush_clr_off", 32'(acc_clr_o), 32'd0);
        chk("flush_hist",    32'(vld_d_o >> 1), 32'd0);
      end
      if (acc_clr_o) begin
        n_clr++;
        clr_j = j;
      end
      tick();
    end
    chk("flush_results", 32'(n_clr), 32'd1);
    chk("flush_clr_cyc", 32'(clr_j), 32'd16);

    // Statistics.
    run_frame(1'b1, 1'b1, 1'b0);
    run_frame(1'b1, 1'b1, 1'b0);
    run_frame(1'b1, 1'b1, 1'b1);
    look();
    chk("stat_ovf3", 32'(ovf_cnt_o), 32'd3);
    chk("stat_udf1", 32'(udf_cnt_o), 32'd1);
    tick();
    run_frame(1'b1, 1'b0, 1'b0);
    look();
    chk("stat_ovf_sat", 32'(ovf_cnt_o), 32'd3);
    chk("stat_udf_keep", 32'(udf_cnt_o), 32'd1);
    tick();

    // Reset in the middle of NORM (Kth fire at k, NORM k+5..k+7).
    for (int j = 0; j < K; j++) begin
      in_valid_i = 1'b1;
      tick();
    end
    in_valid_i = 1'b0;
    repeat (5) tick();
    rst_i = 1'b1;
    look();
    chk("mid_norm_rdy", 32'(acc_rdy_o), 32'd1);
    tick();
    rst_i = 1'b0;
    look();
    chk_reset_vals("rst_norm");
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mac_dot_seq.md
# mac_dot_seq

Sequencer for the dot-product MAC datapath. It accepts a stream of operand beats and counts K products per dot product. After the accumulator pipeline drains, it holds the normaliser's `acc_rdy` for the normaliser's full register depth, clears the accumulator, and presents the normalised result on a valid/ready output. It sits between the input operand buffer and the accumulator/fraction-scale-factor normaliser pair, and also keeps the running overflow/underflow statistics.

## Interface
- `K`, 9: products per dot product (≥2).
- `VLD_DEPTH`, 12: width of the valid-history bus driven to the datapath.
- `ACC_LAT`, 4: cycles from acceptance of the Kth beat until the accumulator carry-save words are final.
- `NORM_LAT`, 3: consecutive `acc_rdy` cycles the normaliser needs (regime register → scale factor/mantissa partials → mantissa sum).
- `CNT_W`, 16: width of the statistics counters.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: **synchronous, active-high reset.**
- `flush_i` in 1: synchronous abort of the current dot product and any pending result.
- `in_valid_i` in 1: operand beat valid.
- `in_ready_o` out 1: operand beat accepted when high together with `in_valid_i` (a "fire").
- `vld_d_o` out VLD_DEPTH: valid history to the datapath stages.
- `acc_rdy_o` out 1: normaliser update enable.
- `acc_clr_o` out 1: one-cycle accumulator clear.
- `ovf_i`, `udf_i`, `nzero_i` in 1 each: normaliser flags.
- `out_valid_o` out 1: normalised result valid (sign/sf/mantissa registers stable).
- `out_ready_i` in 1: result consumed when high together with `out_valid_o`.
- `ovf_cnt_o`, `udf_cnt_o` out CNT_W: saturating event counters.

## Operation
- FSM states:
  - IDLE → ACCUM on the first fire.
  - ACCUM counts fires in `cnt` (width $clog2(K+1)). The Kth fire moves to DRAIN and resets `cnt` to 0.
  - DRAIN waits ACC_LAT cycles (timer `t`). When `t` expires and `res_pend`==0, or `res_pend` is being consumed that same cycle, it moves to NORM. Otherwise it stays in DRAIN (stall).
  - NORM drives `acc_rdy_o`=1 for exactly NORM_LAT cycles. On the last of these cycles it moves to IDLE, then `acc_clr_o` pulses and `res_pend` is set on the next cycle.
- `in_ready_o` = 1 in IDLE and ACCUM, and 0 in DRAIN and NORM. The accumulator inputs are therefore frozen while `acc_rdy_o` is high.
- `out_valid_o` = `res_pend`. It stays asserted until an out-fire. A new frame may accumulate in IDLE/ACCUM while `res_pend`=1. A second DRAIN completion stalls until the out-fire.
- `vld_d_o[VLD_DEPTH-1:1]` is a left shift of the fire history every cycle. `vld_d_o[0]` = fire OR (state≠IDLE) OR `res_pend`. This guarantees the normaliser never sees all-zero `vld_d` while a result is in flight.
- Statistics are sampled on the cycle `res_pend` is set:
  - `ovf_cnt_o` += `ovf_i`.
  - `udf_cnt_o` += (`udf_i` & `nzero_i`); an exact zero is not counted.
  - Both counters saturate at all-ones.
- `flush_i`:
  - forces IDLE, `cnt`=0, `t`=0, history=0, `res_pend`=0, `acc_rdy_o`=0, `acc_clr_o`=1 for that one cycle.
  - leaves the statistics unchanged.
  - Priority: `rst_i` > `flush_i` > normal operation.

## Timing
- Reset values: state IDLE, `in_ready_o`=1 after reset, and all of the following at 0: `vld_d_o`, `acc_rdy_o`, `acc_clr_o`, `out_valid_o`, `ovf_cnt_o`, `udf_cnt_o`. `cnt` and `t` are also 0.
- Kth fire at cycle c, no stall:
  - `acc_rdy_o` high in cycles c+ACC_LAT+1 … c+ACC_LAT+NORM_LAT.
  - `acc_clr_o` and `out_valid_o` rise in cycle c+ACC_LAT+NORM_LAT+1.
  - `in_ready_o` rises again in that same cycle.
- Stall: `acc_rdy_o` first rises the cycle after the out-fire that releases DRAIN.
- Out-fire and the setting of a new `res_pend` are never in the same cycle, because NORM separates them.
- A flush during NORM drops the partial normaliser update. The normaliser's state is then irrelevant because `out_valid_o`=0.

## Structure
- Shared package holds:
  - state enum {IDLE, ACCUM, DRAIN, NORM};
  - default constants ACC_LAT/NORM_LAT, so the accumulator and normaliser owners change them in one place.
- One sub-module: `sat_counter` (parameter width; inc, clr → saturating count), instantiated twice.
- The FSM, timers and history register stay in the top module.

## Test plan
- K=9, `in_valid_i` constant 1, `out_ready_i`=1: nine fires (c0..c8), then:
  - `acc_rdy_o` high c13..c15;
  - `acc_clr_o`/`out_valid_o` at c16;
  - `in_ready_o`=0 c9..c15.
- `out_ready_i`=0 while a second frame completes: DRAIN stalls and `acc_rdy_o` stays 0. Raising `out_ready_i` at cycle r gives `acc_rdy_o` at r+1..r+3.
- Gapped input, `in_valid_i` toggling 1/0: `vld_d_o` history matches the fire pattern shifted each cycle, and `vld_d_o`≠0 from the first fire until the result is consumed.
- `flush_i` pulse on the 5th fire: one-cycle `acc_clr_o`, `cnt`=0, and the next 9 fires produce exactly one result.
- `ovf_i`=1 on 3 results; `udf_i`=1, `nzero_i`=0 on 2 results; `udf_i`=1, `nzero_i`=1 on 1 result. Expect `ovf_cnt_o`=3, `udf_cnt_o`=1. With CNT_W=2, `ovf_cnt_o` saturates at 3 after a 4th overflow.
- `rst_i` asserted mid-NORM: next cycle all outputs are at their reset values and `in_ready_o`=1.
